// File: rtl/i2c_line_conditioner_if.sv
// i2c_line_conditioner_if: raw pad inputs and conditioned line/event outputs of the I2C front end
interface i2c_line_conditioner_if;
    logic scl_pad_i, sda_pad_i;
    logic scl_i, sda_i, scl_rise, scl_fall, start_det, stop_det, bus_busy, bus_timeout;
    modport slave (
        input  scl_pad_i, sda_pad_i,
        output scl_i, sda_i, scl_rise, scl_fall, start_det, stop_det, bus_busy, bus_timeout
    );
    modport master (
        output scl_pad_i, sda_pad_i,
        input  scl_i, sda_i, scl_rise, scl_fall, start_det, stop_det, bus_busy, bus_timeout
    );
endinterface

// File: rtl/i2c_line_conditioner.sv
// i2c_line_conditioner: sync, glitch-filter and event-detect SCL/SDA with bus-busy tracking
// I2C_COND_TIMEOUT_EN adds a stuck-SCL timeout that forces the bus back to idle.
module i2c_line_conditioner #(
    parameter int FILTER_LEN     = 3,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input logic                   CLK,
    input logic                   RESET,
    i2c_line_conditioner_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state_q, state_d;
    // bit 0 carries SCL, bit 1 carries SDA
    logic [1:0] sync1_q, sync1_d, sync2_q, sync2_d, filt_q, filt_d, dly_q, dly_d;
    logic [1:0][3:0] cnt_q, cnt_d;
    logic scl_high;
    always_comb begin
        sync1_d = {bus.sda_pad_i, bus.scl_pad_i};
        sync2_d = sync1_q;
        dly_d   = filt_q;
        filt_d  = filt_q;
        cnt_d   = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != filt_q[i]) begin
                if (cnt_q[i] + 4'd1 == 4'(FILTER_LEN)) filt_d[i] = sync2_q[i];
                else cnt_d[i] = cnt_q[i] + 4'd1;
            end
        end
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1_q <= '1;
            sync2_q <= '1;
            filt_q  <= '1;
            dly_q   <= '1;
            cnt_q   <= '0;
            state_q <= IDLE;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            filt_q  <= filt_d;
            dly_q   <= dly_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end
    // SDA moves only count as START/STOP when SCL was and still is high
    assign scl_high      = filt_q[0] & dly_q[0];
    assign bus.scl_i     = filt_q[0];
    assign bus.sda_i     = filt_q[1];
    assign bus.scl_rise  = filt_q[0] & ~dly_q[0];
    assign bus.scl_fall  = ~filt_q[0] & dly_q[0];
    assign bus.start_det = scl_high & ~filt_q[1] & dly_q[1];
    assign bus.stop_det  = scl_high & filt_q[1] & ~dly_q[1];
    assign bus.bus_busy  = state_q == BUSY;
`ifdef I2C_COND_TIMEOUT_EN
    logic [15:0] to_q, to_d;
    // saturates at TIMEOUT_CYCLES so a still-low SCL cannot retrigger the pulse
    always_comb begin
        to_d = bus.scl_i ? '0 : to_q == 16'(TIMEOUT_CYCLES) ? to_q : state_q == BUSY ? to_q + 16'd1 : '0;
    end
    always_ff @(posedge CLK) begin
        if (RESET) to_q <= '0;
        else to_q <= to_d;
    end
    assign bus.bus_timeout = state_q == BUSY && !bus.scl_i && to_q == 16'(TIMEOUT_CYCLES - 1);
`else
    assign bus.bus_timeout = 1'b0;
`endif
    always_comb begin
        state_d = state_q == IDLE ? (bus.start_det ? BUSY : IDLE)
                                  : (bus.stop_det || bus.bus_timeout ? IDLE : BUSY);
    end
endmodule
